wb_intercon_n: RTL and testbench

- Parametrised successor to the fixed four-slave Wishbone interconnect.
- Single Wishbone master (the moxie core) to NUM_SLAVES slaves over flattened slave buses, with mask/address decode.
- Registered decode stage and a bus-error response for unmapped addresses.
- Optional transaction watchdog that terminates hung slave cycles with an error.

---
 rtl/wb_intercon_n.sv | 196 +++++++++++++++++++
 tb/tb_wb_intercon_n.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_intercon_n.sv
// -----------------------------------------------------------------------------
// wb_intercon_n
//   Single-master to NUM_SLAVES-slave Wishbone interconnect. A registered
//   decode stage picks one slave per transfer by base/mask match. The lowest
//   index wins when regions overlap, and a mask of zero disables a slave. An
//   access that matches no slave receives a one-cycle bus error.
//
//   Optional macro WB_INTERCON_TIMEOUT_EN adds a transaction watchdog. A slave
//   that has not answered within TIMEOUT_CYCLES ACTIVE cycles loses its
//   cyc/stb, and the master receives a bus error.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   wbm_*               master side (address, data, sel, we, cyc, stb in;
//                       read data, ack, err out)
//   wbs_*               flattened slave side. Slave k uses slice
//                       [k*W +: W] of each vector. Address, write data,
//                       byte selects and we are broadcast to every slave;
//                       cyc and stb go to the granted slave only.
// -----------------------------------------------------------------------------
module wb_intercon_n #(
   parameter int unsigned                   NUM_SLAVES     = 4,
   parameter int unsigned                   ADDR_W         = 32,
   parameter int unsigned                   DATA_W         = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_ADDR     = {NUM_SLAVES{{ADDR_W{1'b1}}}},
   parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_MASK     = '0,
   parameter int unsigned                   TIMEOUT_CYCLES = 255
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [ADDR_W-1:0]              wbm_adr_i,
   input  logic [DATA_W-1:0]              wbm_dat_i,
   output logic [DATA_W-1:0]              wbm_dat_o,
   input  logic [DATA_W/8-1:0]            wbm_sel_i,
   input  logic                           wbm_we_i,
   input  logic                           wbm_cyc_i,
   input  logic                           wbm_stb_i,
   output logic                           wbm_ack_o,
   output logic                           wbm_err_o,
   output logic [NUM_SLAVES*ADDR_W-1:0]   wbs_adr_o,
   output logic [NUM_SLAVES*DATA_W-1:0]   wbs_dat_o,
   input  logic [NUM_SLAVES*DATA_W-1:0]   wbs_dat_i,
   output logic [NUM_SLAVES*DATA_W/8-1:0] wbs_sel_o,
   output logic [NUM_SLAVES-1:0]          wbs_we_o,
   output logic [NUM_SLAVES-1:0]          wbs_cyc_o,
   output logic [NUM_SLAVES-1:0]          wbs_stb_o,
   input  logic [NUM_SLAVES-1:0]          wbs_ack_i,
   input  logic [NUM_SLAVES-1:0]          wbs_err_i
);

   if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 1 ||
       TIMEOUT_CYCLES > 65535 || (DATA_W % 8) != 0) begin : g_param_check
      $error("wb_intercon_n: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_e;

   state_e                  state_q, state_d;
   logic [NUM_SLAVES-1:0]   grant_q, grant_d;
   logic [NUM_SLAVES-1:0]   hit_vec;
   logic                    hit;
   logic [DATA_W-1:0]       slv_dat;
   logic                    slv_ack, slv_err;
   logic [NUM_SLAVES-1:0]   cyc_d, stb_d;
   logic                    ack_d, err_d, we_en;
   logic [DATA_W-1:0]       dat_d;

`ifdef WB_INTERCON_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]            cnt_q, cnt_d;
`endif

   // Address decode: the first matching enabled slave wins.
   always_comb begin
      hit_vec = '0;
      hit     = 1'b0;
      for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
         if (!hit && SLAVE_MASK[k*ADDR_W +: ADDR_W] != '0 &&
             ((wbm_adr_i & SLAVE_MASK[k*ADDR_W +: ADDR_W]) ==
              (SLAVE_ADDR[k*ADDR_W +: ADDR_W] & SLAVE_MASK[k*ADDR_W +: ADDR_W]))) begin
            hit_vec[k] = 1'b1;
            hit        = 1'b1;
         end
      end
   end

   // Return path muxed through the one-hot grant register.
   always_comb begin
      slv_dat = '0;
      for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
         if (grant_q[k]) begin
            slv_dat |= wbs_dat_i[k*DATA_W +: DATA_W];
         end
      end
      slv_ack = |(grant_q & wbs_ack_i);
      slv_err = |(grant_q & wbs_err_i);
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cyc_d   = '0;
      stb_d   = '0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_d   = '0;
      we_en   = 1'b0;
`ifdef WB_INTERCON_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef WB_INTERCON_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (wbm_cyc_i && wbm_stb_i) begin
               if (hit) begin
                  grant_d = hit_vec;
                  state_d = ACTIVE;
               end else begin
                  state_d = ERR;
               end
            end
         end
         ACTIVE: begin
            dat_d = slv_dat;
            we_en = 1'b1;
            if (!wbm_cyc_i) begin
               // master abort: slave cyc already low, no response forwarded
               state_d = IDLE;
            end else if (slv_ack || slv_err) begin
               cyc_d   = grant_q;
               stb_d   = grant_q & {NUM_SLAVES{wbm_stb_i}};
               err_d   = slv_err;
               ack_d   = slv_ack & ~slv_err;
               state_d = IDLE;
`ifdef WB_INTERCON_TIMEOUT_EN
            end else if (cnt_q == TMO_LAST) begin
               // watchdog expiry: slave cyc/stb dropped this cycle
               state_d = ERR;
            end else begin
               cyc_d = grant_q;
               stb_d = grant_q & {NUM_SLAVES{wbm_stb_i}};
               cnt_d = cnt_q + 16'd1;
`else
            end else begin
               cyc_d = grant_q;
               stb_d = grant_q & {NUM_SLAVES{wbm_stb_i}};
`endif
            end
         end
         ERR: begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Outputs are held quiet while reset is asserted, so a slave ack in that
      // cycle never reaches the master.
      if (rst_i) begin
         cyc_d = '0;
         stb_d = '0;
         ack_d = 1'b0;
         err_d = 1'b0;
         dat_d = '0;
         we_en = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
`ifdef WB_INTERCON_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
`ifdef WB_INTERCON_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
   assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
   assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
   assign wbs_we_o  = {NUM_SLAVES{wbm_we_i & we_en}};
   assign wbs_cyc_o = cyc_d;
   assign wbs_stb_o = stb_d;
   assign wbm_ack_o = ack_d;
   assign wbm_err_o = err_d;
   assign wbm_dat_o = dat_d;

endmodule

// File: tb/tb_wb_intercon_n.sv
// -----------------------------------------------------------------------------
// tb_wb_intercon_n
//   Randomised transaction bench for wb_intercon_n. Each transfer is expanded
//   cycle by cycle from the address map and the chosen slave behaviour into
//   expected master/slave outputs. A single negedge process compares these
//   expectations against the DUT.
// -----------------------------------------------------------------------------
module tb_wb_intercon_n;
   localparam int unsigned NS  = 4;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = DW / 8;
   localparam int unsigned TMO = 16;
   localparam logic [NS*AW-1:0] S_ADDR = {32'h0002_0000, 32'h0000_1000, 32'h0001_0000, 32'h0000_0000};
   localparam logic [NS*AW-1:0] S_MASK = {32'h0000_0000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000};

   localparam int M_ACK   = 0;
   localparam int M_ERR   = 1;
   localparam int M_BOTH  = 2;
   localparam int M_ABORT = 3;
   localparam int M_HANG  = 4;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [AW-1:0]     wbm_adr_i;
   logic [DW-1:0]     wbm_dat_i;
   logic [DW-1:0]     wbm_dat_o;
   logic [SW-1:0]     wbm_sel_i;
   logic              wbm_we_i, wbm_cyc_i, wbm_stb_i;
   logic              wbm_ack_o, wbm_err_o;
   logic [NS*AW-1:0]  wbs_adr_o;
   logic [NS*DW-1:0]  wbs_dat_o;
   logic [NS*DW-1:0]  wbs_dat_i;
   logic [NS*SW-1:0]  wbs_sel_o;
   logic [NS-1:0]     wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i, wbs_err_i;

   wb_intercon_n #(
      .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
      .SLAVE_ADDR(S_ADDR), .SLAVE_MASK(S_MASK), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
      .wbm_sel_i(wbm_sel_i), .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i),
      .wbm_stb_i(wbm_stb_i), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
      .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_dat_i(wbs_dat_i),
      .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o),
      .wbs_stb_o(wbs_stb_o), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
   );

   always #5 clk_i = ~clk_i;

   // Address map as seen by the model.
   logic [31:0] m_base [NS] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_1000, 32'h0002_0000};
   logic [31:0] m_mask [NS] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'h0000_0000};

   function automatic int decode(input logic [31:0] a);
      for (int k = 0; k < int'(NS); k++) begin
         if (m_mask[k] != 32'h0 && (a & m_mask[k]) == (m_base[k] & m_mask[k])) return k;
      end
      return -1;
   endfunction

   int checks = 0;
   int errors = 0;

   logic          exp_en  = 1'b0;
   logic          exp_rst = 1'b0;
   logic          exp_ack, exp_err;
   logic [NS-1:0] exp_cyc, exp_stb;
   logic [DW-1:0] exp_dat;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk_i) begin
      if (exp_en) begin
         chk("wbm_ack_o", wbm_ack_o, exp_ack);
         chk("wbm_err_o", wbm_err_o, exp_err);
         chk("wbm_dat_o", wbm_dat_o, exp_dat);
         chk("wbs_cyc_o", wbs_cyc_o, exp_cyc);
         chk("wbs_stb_o", wbs_stb_o, exp_stb);
         if (exp_cyc != '0) begin
            chk("wbs_adr_o", wbs_adr_o, {NS{wbm_adr_i}});
            chk("wbs_dat_o", wbs_dat_o, {NS{wbm_dat_i}});
            chk("wbs_sel_o", wbs_sel_o, {NS{wbm_sel_i}});
            chk("wbs_we_o",  wbs_we_o,  {NS{wbm_we_i}});
         end
         if (exp_rst) chk("wbs_we_o_reset", wbs_we_o, '0);
      end
   end

   task automatic set_exp(input logic a, input logic e, input logic [NS-1:0] c,
                          input logic [NS-1:0] s, input logic [DW-1:0] d);
      exp_en  = 1'b1;
      exp_rst = 1'b0;
      exp_ack = a;
      exp_err = e;
      exp_cyc = c;
      exp_stb = s;
      exp_dat = d;
   endtask

   // Random data everywhere, random ack/err on every slave except tgt.
   task automatic slaves_rand(input int tgt);
      wbs_dat_i = {$urandom, $urandom, $urandom, $urandom};
      wbs_ack_i = NS'($urandom);
      wbs_err_i = NS'($urandom);
      if (tgt >= 0) begin
         wbs_ack_i[tgt] = 1'b0;
         wbs_err_i[tgt] = 1'b0;
      end
   endtask

   function automatic logic [DW-1:0] sd(input int k);
      return wbs_dat_i[k*int'(DW) +: DW];
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         wbm_cyc_i = 1'b0;
         wbm_stb_i = 1'b0;
         slaves_rand(-1);
         set_exp(1'b0, 1'b0, '0, '0, '0);
      end
   endtask

   // One master transfer. Cycle 0 presents the request; the DUT answers from
   // cycle 1 on. w is the number of silent ACTIVE cycles before the response
   // (or, for M_ABORT, the ACTIVE cycle in which the master drops cyc).
   task automatic txn(input logic [31:0] adr, input logic we, input int mode,
                      input int w, input logic [31:0] rdat);
      int            tgt;
      logic [NS-1:0] oh;
      tgt = decode(adr);
      oh  = '0;
      if (tgt >= 0) oh[tgt] = 1'b1;

      step();
      wbm_adr_i = adr;
      wbm_we_i  = we;
      wbm_sel_i = SW'($urandom);
      wbm_dat_i = $urandom;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      slaves_rand(-1);
      set_exp(1'b0, 1'b0, '0, '0, '0);

      if (tgt < 0) begin
         step();
         slaves_rand(-1);
         set_exp(1'b0, 1'b1, '0, '0, '0);
         return;
      end

      if (mode == M_HANG) begin
`ifdef WB_INTERCON_TIMEOUT_EN
         for (int c = 1; c < int'(TMO); c++) begin
            step();
            slaves_rand(tgt);
            set_exp(1'b0, 1'b0, oh, oh, sd(tgt));
         end
         step();
         slaves_rand(tgt);
         set_exp(1'b0, 1'b0, '0, '0, sd(tgt));
         step();
         slaves_rand(-1);
         set_exp(1'b0, 1'b1, '0, '0, '0);
`else
         for (int c = 1; c <= 100; c++) begin
            step();
            slaves_rand(tgt);
            set_exp(1'b0, 1'b0, oh, oh, sd(tgt));
         end
         step();
         wbm_cyc_i = 1'b0;
         wbm_stb_i = 1'b0;
         slaves_rand(tgt);
         set_exp(1'b0, 1'b0, '0, '0, sd(tgt));
`endif
         return;
      end

      if (mode == M_ABORT) begin
         for (int c = 1; c < w; c++) begin
            step();
            slaves_rand(tgt);
            set_exp(1'b0, 1'b0, oh, oh, sd(tgt));
         end
         step();
         wbm_cyc_i = 1'b0;
         wbm_stb_i = 1'b0;
         slaves_rand(tgt);
         set_exp(1'b0, 1'b0, '0, '0, sd(tgt));
         return;
      end

      for (int c = 1; c <= w; c++) begin
         step();
         slaves_rand(tgt);
         set_exp(1'b0, 1'b0, oh, oh, sd(tgt));
      end
      step();
      slaves_rand(tgt);
      wbs_dat_i[tgt*int'(DW) +: DW] = rdat;
      wbs_ack_i[tgt] = (mode == M_ACK || mode == M_BOTH);
      wbs_err_i[tgt] = (mode == M_ERR || mode == M_BOTH);
      set_exp(mode == M_ACK, mode != M_ACK, oh, oh, rdat);
   endtask

   initial begin
      logic [31:0] a;
      int          r, mode, w;

      rst_i     = 1'b1;
      wbm_adr_i = '0;
      wbm_dat_i = '0;
      wbm_sel_i = '0;
      wbm_we_i  = 1'b0;
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      wbs_dat_i = '0;
      wbs_ack_i = '0;
      wbs_err_i = '0;

      // Pin the model's address map.
      chk("model_decode_1010",  decode(32'h0000_1010), 0);
      chk("model_decode_10004", decode(32'h0001_0004), 1);
      chk("model_decode_20000", decode(32'h0002_0000), -1);
      chk("model_decode_8000",  decode(32'h8000_0000), -1);

      // Reset with a live request and noisy slaves: everything stays quiet.
      for (int i = 0; i < 3; i++) begin
         step();
         rst_i     = 1'b1;
         wbm_adr_i = 32'h0000_1004;
         wbm_we_i  = 1'b1;
         wbm_cyc_i = 1'b1;
         wbm_stb_i = 1'b1;
         slaves_rand(-1);
         set_exp(1'b0, 1'b0, '0, '0, '0);
         exp_rst = 1'b1;
      end
      step();
      rst_i     = 1'b0;
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      set_exp(1'b0, 1'b0, '0, '0, '0);
      idle(1);

      // Zero-wait read, unmapped write, overlap resolution, ack+err together.
      txn(32'h0000_1004, 1'b0, M_ACK, 0, 32'hDEAD_BEEF);
      idle(1);
      txn(32'h8000_0000, 1'b1, M_ACK, 0, 32'h0);
      idle(1);
      txn(32'h0000_1010, 1'b0, M_ACK, 2, 32'h1234_5678);
      txn(32'h0001_0020, 1'b1, M_BOTH, 1, 32'hCAFE_F00D);
      txn(32'h0001_0024, 1'b0, M_ERR, 0, 32'h0BAD_0BAD);
      // Master abort in ACTIVE cycle 3, then an immediate new transfer.
      txn(32'h0000_0024, 1'b0, M_ABORT, 3, 32'h0);
      txn(32'h0001_0000, 1'b0, M_ACK, 0, 32'h5555_AAAA);
      idle(2);
      // Slave that never answers.
      txn(32'h0001_0000, 1'b0, M_HANG, 0, 32'h0);
      idle(2);
      // Ack arriving in the last cycle before watchdog expiry.
      txn(32'h0000_0100, 1'b1, M_ACK, int'(TMO) - 1, 32'hA5A5_5A5A);
      idle(1);

      // Reset in the middle of an ACTIVE transfer with a slave ack pending.
      step();
      wbm_adr_i = 32'h0001_0010;
      wbm_we_i  = 1'b1;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      slaves_rand(-1);
      set_exp(1'b0, 1'b0, '0, '0, '0);
      step();
      slaves_rand(1);
      set_exp(1'b0, 1'b0, 4'b0010, 4'b0010, sd(1));
      step();
      rst_i = 1'b1;
      slaves_rand(-1);
      wbs_ack_i[1] = 1'b1;
      set_exp(1'b0, 1'b0, '0, '0, '0);
      exp_rst = 1'b1;
      step();
      rst_i     = 1'b0;
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      slaves_rand(-1);
      set_exp(1'b0, 1'b0, '0, '0, '0);
      idle(1);

      // Random traffic.
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 3))
            0:       a = 32'h0000_0000 | 32'($urandom_range(0, 32'hFFFF));
            1:       a = 32'h0001_0000 | 32'($urandom_range(0, 32'hFFFF));
            2:       a = 32'h0002_0000 | 32'($urandom_range(0, 32'hFFFF));
            default: a = $urandom;
         endcase
         r    = int'($urandom_range(0, 99));
         mode = (r < 50) ? M_ACK : (r < 65) ? M_ERR : (r < 75) ? M_BOTH : M_ABORT;
         w    = (mode == M_ABORT) ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 5));
         txn(a, 1'($urandom), mode, w, $urandom);
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
      end
      idle(2);

      step();
      exp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
